// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ctrl_bytes byte-stream Wishbone controller.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GET_DATA,
        ST_WB_REQ,
        ST_TX_RESP
    } state_e;

    localparam int unsigned CMD_WE_BIT  = 7;
    localparam int unsigned CMD_ADR_MSB = 3;
    localparam int unsigned CMD_ADR_LSB = 0;
    localparam int unsigned ADR_W       = 4;
    localparam int unsigned DAT_W       = 8;

    localparam logic [DAT_W-1:0] TIMEOUT_BYTE = 8'hFF;

endpackage

// File: rtl/ctrl_bytes.sv
// Command byte stream to single Wishbone B4 cycles; read data returned on tx.
// Optional bus timeout enabled by defining CTRL_BYTES_TIMEOUT_EN.
module ctrl_bytes
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DAT_W-1:0] rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    output logic [DAT_W-1:0] tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [DAT_W-1:0] wb_dat_o,
    output logic             wb_stb_o,
    input  logic [DAT_W-1:0] wb_dat_i,
    input  logic             wb_ack_i
);

    state_e           state_q, state_d;
    logic             alive_q;
    logic             we_q;
    logic [ADR_W-1:0] adr_q;
    logic [DAT_W-1:0] dat_q;
    logic [DAT_W-1:0] rdata_q;
    logic [DAT_W-1:0] rdata_d;
    logic             ld_cmd, ld_dat, ld_rd;
    logic             rx_fire;
    logic             timeout_hit;
    logic [2:0]       unused_rsvd;

    assign unused_rsvd = rx_data_i[6:4];

    // alive_q holds rx_ready low while reset is asserted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign rx_ready_o = alive_q &&
                        (state_q == ST_IDLE || state_q == ST_GET_DATA);
    assign rx_fire    = rx_valid_i && rx_ready_o;
    assign wb_stb_o   = (state_q == ST_WB_REQ);
    assign tx_valid_o = (state_q == ST_TX_RESP);
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign tx_data_o  = rdata_q;

`ifdef CTRL_BYTES_TIMEOUT_EN
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

    logic [CNT_W-1:0] cnt_q;

    // Counter rests at zero outside WB_REQ, so every entry starts fresh.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q != ST_WB_REQ) begin
            cnt_q <= '0;
        end else if (!wb_ack_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ld_cmd  = 1'b0;
        ld_dat  = 1'b0;
        ld_rd   = 1'b0;
        rdata_d = wb_dat_i;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_fire) begin
                    ld_cmd  = 1'b1;
                    state_d = rx_data_i[CMD_WE_BIT] ? ST_GET_DATA : ST_WB_REQ;
                end
            end
            ST_GET_DATA: begin
                if (rx_fire) begin
                    ld_dat  = 1'b1;
                    state_d = ST_WB_REQ;
                end
            end
            ST_WB_REQ: begin
                // An ack arriving on the expiry edge takes priority.
                if (wb_ack_i) begin
                    ld_rd   = !we_q;
                    state_d = we_q ? ST_IDLE : ST_TX_RESP;
                end else if (timeout_hit) begin
                    ld_rd   = !we_q;
                    rdata_d = TIMEOUT_BYTE;
                    state_d = we_q ? ST_IDLE : ST_TX_RESP;
                end
            end
            ST_TX_RESP: begin
                if (tx_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (ld_cmd) begin
                we_q  <= rx_data_i[CMD_WE_BIT];
                adr_q <= rx_data_i[CMD_ADR_MSB:CMD_ADR_LSB];
            end
            if (ld_dat) begin
                dat_q <= rx_data_i;
            end
            if (ld_rd) begin
                rdata_q <= rdata_d;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_bytes.sv
// Self-checking bench for ctrl_bytes: directed cases plus random command traffic.
module tb_ctrl_bytes;

    localparam int unsigned TO_CYC = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic       rx_valid_i = 1'b0;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i = 1'b0;
    logic       wb_we_o;
    logic [3:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic       wb_stb_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;

    logic       ack_en = 1'b1;
    logic [7:0] periph_mem [16];
    logic [7:0] ref_mem [16];
    int         stb_cnt = 0;
    int         tx_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    ctrl_bytes #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Register-file peripheral with a combinational ack.
    assign wb_ack_i = wb_stb_o && ack_en;
    assign wb_dat_i = periph_mem[wb_adr_o];

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) periph_mem[i] <= 8'h00;
        end else if (wb_stb_o && wb_ack_i && wb_we_o) begin
            periph_mem[wb_adr_o] <= wb_dat_o;
        end
    end

    always @(negedge clk_i) begin
        if (wb_stb_o) stb_cnt <= stb_cnt + 1;
        if (tx_valid_o) tx_cnt <= tx_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("rx_accept_wait", 32'(n < 20), 1);
        @(posedge clk_i);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] dat);
        int s0 = stb_cnt;
        int t0 = tx_cnt;
        send_byte(cmd);
        send_byte(dat);
        chk("wr_stb", wb_stb_o, 1);
        chk("wr_we", wb_we_o, 1);
        chk("wr_adr", wb_adr_o, cmd[3:0]);
        chk("wr_dat", wb_dat_o, dat);
        @(negedge clk_i);
        chk("wr_stb_drop", wb_stb_o, 0);
        chk("wr_rdy_again", rx_ready_o, 1);
        chk("wr_stb_cycles", stb_cnt - s0, 1);
        chk("wr_no_tx", tx_cnt - t0, 0);
        ref_mem[cmd[3:0]] = dat;
    endtask

    task automatic do_read(input logic [7:0] cmd, input int dly);
        logic [7:0] exp = ref_mem[cmd[3:0]];
        int s0 = stb_cnt;
        int t0 = tx_cnt;
        send_byte(cmd);
        chk("rd_stb", wb_stb_o, 1);
        chk("rd_we", wb_we_o, 0);
        chk("rd_adr", wb_adr_o, cmd[3:0]);
        @(negedge clk_i);
        chk("rd_txv", tx_valid_o, 1);
        chk("rd_txd", tx_data_o, exp);
        chk("rd_stb_drop", wb_stb_o, 0);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk_i);
            chk("rd_hold_txv", tx_valid_o, 1);
            chk("rd_hold_txd", tx_data_o, exp);
            chk("rd_hold_rdy", rx_ready_o, 0);
        end
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        chk("rd_txv_drop", tx_valid_o, 0);
        chk("rd_rdy_again", rx_ready_o, 1);
        chk("rd_stb_cycles", stb_cnt - s0, 1);
        chk("rd_tx_cycles", tx_cnt - t0, dly + 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk_i);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_txv", tx_valid_o, 0);
        chk("rst_rdy", rx_ready_o, 0);
        chk("rst_outs", {wb_we_o, wb_adr_o, wb_dat_o, tx_data_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rdy_after_rst", rx_ready_o, 1);

        do_write(8'h81, 8'hA5);
        do_write(8'h82, 8'h3C);
        do_read(8'h02, 0);
        do_read(8'h01, 5);
        do_write(8'hF3, 8'h11);
        do_read(8'h73, 2);

        // Reset in the middle of a read request.
        ack_en = 1'b0;
        send_byte(8'h02);
        chk("mid_stb", wb_stb_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_stb", wb_stb_o, 0);
        chk("arst_txv", tx_valid_o, 0);
        chk("arst_rdy", rx_ready_o, 0);
        chk("arst_outs", {wb_we_o, wb_adr_o, wb_dat_o, tx_data_o}, 0);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        @(negedge clk_i);
        ack_en = 1'b1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rdy_after_arst", rx_ready_o, 1);
        do_write(8'h81, 8'h55);
        do_read(8'h01, 0);

        // Peripheral withholds ack.
        ack_en = 1'b0;
        send_byte(8'h05);
`ifdef CTRL_BYTES_TIMEOUT_EN
        repeat (TO_CYC - 1) @(negedge clk_i);
        chk("to_stb_last", wb_stb_o, 1);
        @(negedge clk_i);
        chk("to_stb_drop", wb_stb_o, 0);
        chk("to_txv", tx_valid_o, 1);
        chk("to_txd", tx_data_o, 8'hFF);
        ack_en = 1'b1;
`else
        repeat (30) @(negedge clk_i);
        chk("stall_stb", wb_stb_o, 1);
        chk("stall_txv", tx_valid_o, 0);
        ack_en = 1'b1;
        @(negedge clk_i);
        chk("stall_txv_late", tx_valid_o, 1);
        chk("stall_txd", tx_data_o, ref_mem[5]);
`endif
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        tx_ready_i = 1'b0;
        chk("stall_done", tx_valid_o, 0);

        // Random command traffic against the register-file reference.
        for (int k = 0; k < 60; k++) begin
            logic [7:0] cmd;
            cmd = 8'($urandom);
            if (cmd[7]) do_write(cmd, 8'($urandom));
            else do_read(cmd, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
